photonic_argmax_readout: RTL and testbench
==========================================

# photonic_argmax_readout

Downstream readout stage for the photonic layer chain: consumes the PRECISION-bit sample stream emitted by the last layer (valid-qualified, no backpressure), groups it into frames of NUM_CLASSES samples, and computes the winning class index and its value per frame. The result is presented on a ready/valid output port and held until accepted, with a sticky overrun flag if results are lost.

## Interface
- PRECISION, 8, sample width (matches layer data_out)
- NUM_CLASSES, 128, samples per frame (= last layer OUTPUT_SIZE); legal range 1..65535
- IDX_W, $clog2(NUM_CLASSES) (min 1), class index width
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- data_in  input  PRECISION  sample from last photonic layer
- valid_in  input  1  data_in valid this cycle; always accepted
- result_idx  output  IDX_W  winning class index
- result_value  output  PRECISION  value of winning sample
- result_valid  output  1  result registers hold an unconsumed result
- result_ready  input  1  downstream accepts result
- overrun  output  1  sticky: an unconsumed result was overwritten
- frame_count  output  16  completed frames since reset, wraps at 65535→0

## Operation
- States: S_IDLE (sample counter 0, no partial frame), S_ACCUM (1..NUM_CLASSES-1 samples taken).
- S_IDLE + valid_in: load running max = data_in, running idx = 0, counter = 1; → S_ACCUM (if NUM_CLASSES==1, frame completes immediately, stay S_IDLE).
- S_ACCUM + valid_in: if data_in > running max (unsigned, strict), update max and idx = counter; counter++. Ties keep lowest index.
- Frame completes on the valid sample with counter == NUM_CLASSES-1: final compare includes that sample; result_idx/result_value loaded with final winner; result_valid set; frame_count++; counter → 0; → S_IDLE.
- valid_in low: no state change; gaps of any length within a frame allowed.
- Output handshake: result consumed on cycle where result_valid && result_ready; result_valid clears next cycle unless a new frame completes same cycle.
- Completion while result_valid && !result_ready: result overwritten with new frame, result_valid stays 1, overrun set (sticky until rst).
- Completion in same cycle as acceptance: new result loaded, result_valid stays 1, overrun unchanged.
- result_idx/result_value stable while result_valid && !result_ready except on overwrite.
- Reset: discards partial frame; state S_IDLE, counter 0, running max/idx 0.

## Timing
- Reset values: result_idx 0, result_value 0, result_valid 0, overrun 0, frame_count 0.
- Latency: last sample of a frame accepted at cycle t → result_valid=1, result registers updated, frame_count incremented at t+1.
- Acceptance at t (valid&&ready) → result_valid=0 at t+1 (absent new completion).
- Throughput: one sample per cycle sustained; back-to-back frames with no idle cycle; first sample of next frame may arrive at t+1.
- overrun rises at cycle after the overwriting completion.
- rst asserted at any cycle, including the frame-completion cycle: rst wins; all outputs at reset values next cycle.
- Counter width: IDX_W bits; never exceeds NUM_CLASSES-1.

## Structure
- Package photonic_readout_pkg: state enum (S_IDLE, S_ACCUM), FRAME_CNT_W = 16, default PRECISION/NUM_CLASSES constants, index-width helper function.
- One sub-module natural: photonic_result_hold — result register + valid/ready/overrun logic, parameterised on payload width (IDX_W+PRECISION); top holds counter, FSM and compare datapath.

## Test plan
- NUM_CLASSES=4, result_ready=1, samples 10,50,20,30 back-to-back → at t+1 after sample 4: result_idx=1, result_value=50, result_valid=1 for one cycle, frame_count=1.
- Ties and edges: samples 7,7,7,7 → idx 0, value 7; samples 0,0,0,255 → idx 3, value 255; first sample max 255,1,2,3 → idx 0.
- Gaps: frame 5,9,3,1 with valid_in low 3 cycles between each sample → idx 1, value 9; no result before 4th valid sample.
- Backpressure: result_ready=0, two back-to-back frames (max 40 at idx 2, then max 90 at idx 0) → after second frame result_idx=0, result_value=90, result_valid=1, overrun=1; raise ready → valid drops next cycle, overrun stays 1.
- Simultaneous accept+complete: ready pulsed exactly in completion cycle of frame 2 → frame 2 result shown, result_valid stays 1, overrun=0.
- Reset mid-frame: 2 samples of frame, rst 1 cycle, then full frame 1,2,3,4 → idx 3, value 4, frame_count=1; all outputs 0 the cycle after rst.

Source files
------------

// File: rtl/photonic_readout_pkg.sv
// rtl/photonic_readout_pkg.sv - shared types and constants for the photonic argmax readout
package photonic_readout_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_ACCUM = 1'b1} state_t;

  localparam int FRAME_CNT_W     = 16;
  localparam int DEF_PRECISION   = 8;
  localparam int DEF_NUM_CLASSES = 128;

  // A single-class frame still needs a one-bit index/counter.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/photonic_result_hold.sv
// rtl/photonic_result_hold.sv - result register with valid/ready handshake and sticky overrun
module photonic_result_hold #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] payload,
  input  logic         ready,
  output logic [W-1:0] data,
  output logic         valid,
  output logic         overrun
);

  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      data  <= payload;
      valid <= 1'b1;
      // Only a result nobody took counts as lost; same-cycle accept is a clean handoff.
      if (valid && !ready) overrun <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/photonic_argmax_readout.sv
// rtl/photonic_argmax_readout.sv - per-frame argmax over the last photonic layer's sample stream
module photonic_argmax_readout
  import photonic_readout_pkg::*;
#(
  parameter int PRECISION   = DEF_PRECISION,
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int IDX_W       = idx_width(NUM_CLASSES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PRECISION-1:0]   data_in,
  input  logic                   valid_in,
  output logic [IDX_W-1:0]       result_idx,
  output logic [PRECISION-1:0]   result_value,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_t                 state;
  logic [IDX_W-1:0]       count;
  logic [IDX_W-1:0]       run_idx;
  logic [IDX_W-1:0]       next_idx;
  logic [PRECISION-1:0]   run_max;
  logic [PRECISION-1:0]   next_max;
  logic                   frame_done;

  // Winner including the current sample; strict compare keeps the lowest index on ties.
  always_comb begin
    next_max = run_max;
    next_idx = run_idx;
    if (state == S_IDLE) begin
      next_max = data_in;
      next_idx = '0;
    end else if (data_in > run_max) begin
      next_max = data_in;
      next_idx = count;
    end
  end

  assign frame_done = valid_in && (count == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      run_max <= '0;
      run_idx <= '0;
    end else if (valid_in) begin
      run_max <= next_max;
      run_idx <= next_idx;
      if (frame_done) begin
        count <= '0;
        state <= S_IDLE;
      end else begin
        count <= count + IDX_W'(1);
        state <= S_ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             frame_count <= '0;
    else if (frame_done) frame_count <= frame_count + FRAME_CNT_W'(1);
  end

  photonic_result_hold #(
    .W(IDX_W + PRECISION)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .load    (frame_done),
    .payload ({next_idx, next_max}),
    .ready   (result_ready),
    .data    ({result_idx, result_value}),
    .valid   (result_valid),
    .overrun (overrun)
  );

endmodule

// File: tb/tb_photonic_argmax_readout.sv
// tb/tb_photonic_argmax_readout.sv - self-checking bench for photonic_argmax_readout (4-class frames)
module tb_photonic_argmax_readout;

  localparam int NC = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    data_in = '0;
  logic          valid_in = 1'b0;
  logic [IW-1:0] result_idx;
  logic [7:0]    result_value;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic          overrun;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;

  // Reference state: samples of the open frame plus the expected output port.
  logic [7:0]    frame_q[$];
  logic [IW-1:0] exp_idx = '0;
  logic [7:0]    exp_val = '0;
  logic          exp_valid = 1'b0;
  logic          exp_ov = 1'b0;
  logic [15:0]   exp_fc = '0;

  photonic_argmax_readout #(.PRECISION(8), .NUM_CLASSES(NC)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .result_idx(result_idx), .result_value(result_value), .result_valid(result_valid),
    .result_ready(result_ready), .overrun(overrun), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy, input logic r);
    int best;
    logic done;
    valid_in = v; data_in = d; result_ready = rdy; rst = r;
    @(posedge clk);
    #1;
    done = 1'b0;
    if (r) begin
      frame_q.delete();
      exp_idx = '0; exp_val = '0; exp_valid = 1'b0; exp_ov = 1'b0; exp_fc = '0;
    end else begin
      if (v) begin
        frame_q.push_back(d);
        if (frame_q.size() == NC) begin
          best = 0;
          for (int i = 1; i < NC; i++) if (frame_q[i] > frame_q[best]) best = i;
          done = 1'b1;
          if (exp_valid && !rdy) exp_ov = 1'b1;
          exp_idx = IW'(best);
          exp_val = frame_q[best];
          exp_fc  = exp_fc + 16'd1;
          frame_q.delete();
        end
      end
      if (done) exp_valid = 1'b1;
      else if (exp_valid && rdy) exp_valid = 1'b0;
    end
    valid_in = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset;
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    checks += 5;
    if (result_idx !== '0)     begin errors++; $display("FAIL reset_idx got %0d want 0", result_idx); end
    if (result_value !== '0)   begin errors++; $display("FAIL reset_value got %0d want 0", result_value); end
    if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", result_valid); end
    if (overrun !== 1'b0)      begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    if (frame_count !== '0)    begin errors++; $display("FAIL reset_frame_count got %0d want 0", frame_count); end
  endtask

  task automatic test_basic;
    logic [7:0] s[4] = '{8'd10, 8'd50, 8'd20, 8'd30};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, s[i], 1'b1, 1'b0);
      checks++;
      if (result_valid !== (i == 3)) begin errors++; $display("FAIL basic_valid_%0d got %b want %b", i, result_valid, i == 3); end
    end
    checks += 3;
    if (result_idx !== 2'd1)     begin errors++; $display("FAIL basic_idx got %0d want 1", result_idx); end
    if (result_value !== 8'd50)  begin errors++; $display("FAIL basic_value got %0d want 50", result_value); end
    if (frame_count !== 16'd1)   begin errors++; $display("FAIL basic_frame_count got %0d want 1", frame_count); end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", result_valid); end
  endtask

  task automatic test_edges;
    logic [7:0]    s[12] = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd2, 8'd3};
    logic [IW-1:0] wi[3] = '{2'd0, 2'd3, 2'd0};
    logic [7:0]    wv[3] = '{8'd7, 8'd255, 8'd255};
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) cycle(1'b1, s[f*4+i], 1'b1, 1'b0);
      checks += 3;
      if (result_valid !== 1'b1)  begin errors++; $display("FAIL edge%0d_valid got %b want 1", f, result_valid); end
      if (result_idx !== wi[f])   begin errors++; $display("FAIL edge%0d_idx got %0d want %0d", f, result_idx, wi[f]); end
      if (result_value !== wv[f]) begin errors++; $display("FAIL edge%0d_value got %0d want %0d", f, result_value, wv[f]); end
    end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_gaps;
    logic [7:0] s[4] = '{8'd5, 8'd9, 8'd3, 8'd1};
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, s[i], 1'b1, 1'b0);
      if (i < 3) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 8'hAA, 1'b1, 1'b0);
          checks++;
          if (result_valid !== 1'b0) begin errors++; $display("FAIL gap_early_valid got %b want 0", result_valid); end
        end
      end
    end
    checks += 3;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL gap_valid got %b want 1", result_valid); end
    if (result_idx !== 2'd1)   begin errors++; $display("FAIL gap_idx got %0d want 1", result_idx); end
    if (result_value !== 8'd9) begin errors++; $display("FAIL gap_value got %0d want 9", result_value); end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_simultaneous;
    cycle(1'b0, 8'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
    cycle(1'b1, 8'd3, 1'b0, 1'b0);
    cycle(1'b1, 8'd8, 1'b0, 1'b0);
    cycle(1'b1, 8'd6, 1'b0, 1'b0);
    cycle(1'b1, 8'd1, 1'b1, 1'b0);
    checks += 4;
    if (result_valid !== 1'b1) begin errors++; $display("FAIL simul_valid got %b want 1", result_valid); end
    if (result_idx !== 2'd1)   begin errors++; $display("FAIL simul_idx got %0d want 1", result_idx); end
    if (result_value !== 8'd8) begin errors++; $display("FAIL simul_value got %0d want 8", result_value); end
    if (overrun !== 1'b0)      begin errors++; $display("FAIL simul_overrun got %b want 0", overrun); end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic test_backpressure;
    logic [7:0] s[8] = '{8'd10, 8'd20, 8'd40, 8'd5, 8'd90, 8'd1, 8'd2, 8'd3};
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, s[i], 1'b0, 1'b0);
      if (i == 3) begin
        checks += 3;
        if (result_idx !== 2'd2)    begin errors++; $display("FAIL bp_first_idx got %0d want 2", result_idx); end
        if (result_value !== 8'd40) begin errors++; $display("FAIL bp_first_value got %0d want 40", result_value); end
        if (overrun !== 1'b0)       begin errors++; $display("FAIL bp_first_overrun got %b want 0", overrun); end
      end
    end
    checks += 4;
    if (result_valid !== 1'b1)  begin errors++; $display("FAIL bp_valid got %b want 1", result_valid); end
    if (result_idx !== 2'd0)    begin errors++; $display("FAIL bp_idx got %0d want 0", result_idx); end
    if (result_value !== 8'd90) begin errors++; $display("FAIL bp_value got %0d want 90", result_value); end
    if (overrun !== 1'b1)       begin errors++; $display("FAIL bp_overrun got %b want 1", overrun); end
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    checks += 2;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_drop_valid got %b want 0", result_valid); end
    if (overrun !== 1'b1)      begin errors++; $display("FAIL bp_sticky_overrun got %b want 1", overrun); end
  endtask

  task automatic test_reset_midframe;
    cycle(1'b1, 8'd200, 1'b1, 1'b0);
    cycle(1'b1, 8'd201, 1'b1, 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b1);
    checks += 4;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", result_valid); end
    if (overrun !== 1'b0)      begin errors++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
    if (frame_count !== '0)    begin errors++; $display("FAIL rstmid_frame_count got %0d want 0", frame_count); end
    if (result_value !== '0)   begin errors++; $display("FAIL rstmid_value got %0d want 0", result_value); end
    for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0);
    checks += 3;
    if (result_idx !== 2'd3)    begin errors++; $display("FAIL rstmid_idx got %0d want 3", result_idx); end
    if (result_value !== 8'd4)  begin errors++; $display("FAIL rstmid_final_value got %0d want 4", result_value); end
    if (frame_count !== 16'd1)  begin errors++; $display("FAIL rstmid_final_frame_count got %0d want 1", frame_count); end
  endtask

  task automatic test_random;
    logic v, rdy, r;
    for (int c = 0; c < 600; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) == 0);
      r   = ($urandom_range(0, 79) == 0);
      cycle(v, 8'($urandom_range(0, 255)), rdy, r);
      checks += 5;
      if (result_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b want %b", c, result_valid, exp_valid); end
      if (overrun !== exp_ov)         begin errors++; $display("FAIL rand_overrun cyc %0d got %b want %b", c, overrun, exp_ov); end
      if (frame_count !== exp_fc)     begin errors++; $display("FAIL rand_frame_count cyc %0d got %0d want %0d", c, frame_count, exp_fc); end
      if (result_idx !== exp_idx)     begin errors++; $display("FAIL rand_idx cyc %0d got %0d want %0d", c, result_idx, exp_idx); end
      if (result_value !== exp_val)   begin errors++; $display("FAIL rand_value cyc %0d got %0d want %0d", c, result_value, exp_val); end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_edges;
    test_gaps;
    test_simultaneous;
    test_backpressure;
    test_reset;
    test_reset_midframe;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
